i2c_block_assembler: RTL and testbench

- Sits between the I2C slave byte shifter and the DES main controller.
- Decodes the address/RW byte that follows each START and gathers write-direction data bytes MSB-first into 64-bit blocks (key1, key2, plaintext/ciphertext).
- Gives the controller a one-cycle data_ready strobe, the latched transfer direction, and a sticky stop indication.

---
 rtl/des_i2c_pkg.sv | 15 +
 rtl/i2c_block_assembler_if.sv | 26 ++
 rtl/block_shift_reg.sv | 55 +++++
 rtl/i2c_block_assembler.sv | 116 +++++++++++
 tb/tb_i2c_block_assembler.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/des_i2c_pkg.sv
// Shared types and constants for the I2C-to-DES block assembler.
package des_i2c_pkg;

  localparam int unsigned DES_BLOCK_BITS = 64;
  localparam int unsigned BYTE_BITS      = 8;
  localparam logic [6:0]  DEF_SLAVE_ADDR = 7'h3C;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    RECV   = 2'd2,
    IGNORE = 2'd3
  } asm_state_t;

endpackage

// File: rtl/i2c_block_assembler_if.sv
// Byte-shifter strobes in, controller-facing block/ack/status signals out.
interface i2c_block_assembler_if #(
  parameter int unsigned BLOCK_BYTES = des_i2c_pkg::DES_BLOCK_BITS / des_i2c_pkg::BYTE_BITS
);
  logic                     start_detect;
  logic                     stop_detect;
  logic                     byte_valid;
  logic [7:0]               rx_byte;
  logic                     addr_ack;
  logic                     byte_ack;
  logic [8*BLOCK_BYTES-1:0] data_out;
  logic                     data_ready;
  logic                     i2c_rw;
  logic                     i2c_stop;
  logic                     frame_err;

  modport slave (
    input  start_detect, stop_detect, byte_valid, rx_byte,
    output addr_ack, byte_ack, data_out, data_ready, i2c_rw, i2c_stop, frame_err
  );

  modport master (
    output start_detect, stop_detect, byte_valid, rx_byte,
    input  addr_ack, byte_ack, data_out, data_ready, i2c_rw, i2c_stop, frame_err
  );
endinterface

// File: rtl/block_shift_reg.sv
// MSB-first byte shift register with byte counter; loads block_out when a block completes.
module block_shift_reg
  import des_i2c_pkg::*;
#(
  parameter  int unsigned BLOCK_BYTES = DES_BLOCK_BITS / BYTE_BITS,
  localparam int unsigned CNT_W       = $clog2(BLOCK_BYTES),
  localparam int unsigned BLK_W       = BYTE_BITS * BLOCK_BYTES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic [7:0]       byte_in,
  output logic [BLK_W-1:0] block_out,
  output logic [CNT_W-1:0] count,
  output logic             last_c
);

  logic [BLK_W-1:0] shift_q, shift_d;
  logic [BLK_W-1:0] block_q, block_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign last_c    = (count_q == CNT_W'(BLOCK_BYTES - 1));
  assign block_out = block_q;
  assign count     = count_q;

  // A completing shift loads the block even when clear arrives in the same cycle.
  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    block_d = block_q;
    if (shift_en) begin
      shift_d = {shift_q[BLK_W-BYTE_BITS-1:0], byte_in};
      count_d = last_c ? '0 : count_q + CNT_W'(1);
      if (last_c) block_d = shift_d;
    end
    if (clear) begin
      shift_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      count_q <= '0;
      block_q <= '0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
      block_q <= block_d;
    end
  end

endmodule

// File: rtl/i2c_block_assembler.sv
// Decodes the I2C address byte after START and assembles write data into blocks
// for the DES controller, with ack pulses and sticky stop/frame-error status.
module i2c_block_assembler
  import des_i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = DEF_SLAVE_ADDR,
  parameter int unsigned BLOCK_BYTES = DES_BLOCK_BITS / BYTE_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  i2c_block_assembler_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(BLOCK_BYTES);
  localparam int unsigned BLK_W = BYTE_BITS * BLOCK_BYTES;

  asm_state_t       state_q, state_d;
  logic             addr_ack_q, addr_ack_d;
  logic             byte_ack_q, byte_ack_d;
  logic             data_ready_q, data_ready_d;
  logic             i2c_rw_q, i2c_rw_d;
  logic             i2c_stop_q, i2c_stop_d;
  logic             frame_err_q, frame_err_d;
  logic             clear_c, shift_en_c, partial_c;
  logic [BLK_W-1:0] block_out;
  logic [CNT_W-1:0] count;
  logic             last_c;

  block_shift_reg #(.BLOCK_BYTES(BLOCK_BYTES)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear_c),
    .shift_en (shift_en_c),
    .byte_in  (bus.rx_byte),
    .block_out(block_out),
    .count    (count),
    .last_c   (last_c)
  );

  // Bytes left over once this cycle's byte (if any) has been absorbed.
  assign partial_c = bus.byte_valid ? !last_c : (count != '0);

  // START has priority; otherwise the byte is handled before a same-cycle STOP.
  always_comb begin
    state_d      = state_q;
    addr_ack_d   = 1'b0;
    byte_ack_d   = 1'b0;
    data_ready_d = 1'b0;
    i2c_rw_d     = i2c_rw_q;
    i2c_stop_d   = i2c_stop_q;
    frame_err_d  = frame_err_q;
    clear_c      = 1'b0;
    shift_en_c   = 1'b0;
    if (bus.start_detect) begin
      state_d     = ADDR;
      clear_c     = 1'b1;
      i2c_stop_d  = 1'b0;
      frame_err_d = 1'b0;
    end else begin
      if (bus.byte_valid) begin
        case (state_q)
          ADDR: begin
            if (bus.rx_byte[7:1] == SLAVE_ADDR) begin
              addr_ack_d = 1'b1;
              i2c_rw_d   = bus.rx_byte[0];
              state_d    = bus.rx_byte[0] ? IGNORE : RECV;
            end else begin
              state_d = IGNORE;
            end
          end
          RECV: begin
            shift_en_c   = 1'b1;
            byte_ack_d   = 1'b1;
            data_ready_d = last_c;
          end
          default: ;
        endcase
      end
      if (bus.stop_detect) begin
        state_d    = IDLE;
        i2c_stop_d = 1'b1;
        clear_c    = 1'b1;
        if (state_q == RECV && partial_c) frame_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_ack_q   <= 1'b0;
      byte_ack_q   <= 1'b0;
      data_ready_q <= 1'b0;
      i2c_rw_q     <= 1'b0;
      i2c_stop_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_ack_q   <= addr_ack_d;
      byte_ack_q   <= byte_ack_d;
      data_ready_q <= data_ready_d;
      i2c_rw_q     <= i2c_rw_d;
      i2c_stop_q   <= i2c_stop_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.addr_ack   = addr_ack_q;
  assign bus.byte_ack   = byte_ack_q;
  assign bus.data_ready = data_ready_q;
  assign bus.data_out   = block_out;
  assign bus.i2c_rw     = i2c_rw_q;
  assign bus.i2c_stop   = i2c_stop_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_i2c_block_assembler.sv
// Bench for i2c_block_assembler: vector table, directed corner sequences, random traffic vs a queue model.
module tb_i2c_block_assembler;

  localparam int unsigned BB = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2c_block_assembler_if #(.BLOCK_BYTES(BB)) bus();

  i2c_block_assembler #(.SLAVE_ADDR(7'h3C), .BLOCK_BYTES(BB)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int n_aack, n_back, n_rdy;

  typedef enum int {M_IDLE, M_WAIT_ADDR, M_COLLECT, M_DROP} mphase_t;
  mphase_t     m_phase;
  logic [7:0]  m_bytes[$];
  logic [63:0] m_data;
  logic        m_rw, m_stop, m_err, m_aack, m_back, m_rdy;

  typedef struct {
    logic s, p, v;
    logic [7:0] b;
    logic aack, back, rdy, rw, stp, err;
  } vec_t;
  vec_t tbl[11];

  task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_phase = M_IDLE; m_bytes.delete(); m_data = '0;
    m_rw = 0; m_stop = 0; m_err = 0; m_aack = 0; m_back = 0; m_rdy = 0;
  endfunction

  // The addressed device collects write bytes; every BB of them form one MSB-first block.
  function automatic void model_step(input logic s, input logic p, input logic v, input logic [7:0] b);
    logic [63:0] acc;
    m_aack = 0; m_back = 0; m_rdy = 0;
    if (s) begin
      m_phase = M_WAIT_ADDR; m_bytes.delete(); m_stop = 0; m_err = 0;
    end else begin
      if (v) begin
        case (m_phase)
          M_WAIT_ADDR: begin
            if (b[7:1] == 7'h3C) begin
              m_aack = 1; m_rw = b[0];
              m_phase = b[0] ? M_DROP : M_COLLECT;
            end else m_phase = M_DROP;
          end
          M_COLLECT: begin
            m_back = 1;
            m_bytes.push_back(b);
            if (m_bytes.size() == BB) begin
              acc = '0;
              foreach (m_bytes[i]) acc = {acc[55:0], m_bytes[i]};
              m_data = acc; m_rdy = 1;
              m_bytes.delete();
            end
          end
          default: ;
        endcase
      end
      if (p) begin
        if (m_phase == M_COLLECT && m_bytes.size() != 0) m_err = 1;
        m_bytes.delete();
        m_phase = M_IDLE;
        m_stop = 1;
      end
    end
  endfunction

  task automatic compare_model(input string tag);
    check1({tag, "_addr_ack"},   64'(bus.addr_ack),   64'(m_aack));
    check1({tag, "_byte_ack"},   64'(bus.byte_ack),   64'(m_back));
    check1({tag, "_data_ready"}, 64'(bus.data_ready), 64'(m_rdy));
    check1({tag, "_i2c_rw"},     64'(bus.i2c_rw),     64'(m_rw));
    check1({tag, "_i2c_stop"},   64'(bus.i2c_stop),   64'(m_stop));
    check1({tag, "_frame_err"},  64'(bus.frame_err),  64'(m_err));
    check1({tag, "_data_out"},   bus.data_out,        m_data);
  endtask

  task automatic step(input logic s, input logic p, input logic v, input logic [7:0] b);
    @(negedge clk);
    bus.start_detect = s; bus.stop_detect = p; bus.byte_valid = v; bus.rx_byte = b;
    model_step(s, p, v, b);
    @(posedge clk); #1;
    compare_model("model");
    n_aack += int'(bus.addr_ack);
    n_back += int'(bus.byte_ack);
    n_rdy  += int'(bus.data_ready);
    bus.start_detect = 0; bus.stop_detect = 0; bus.byte_valid = 0; bus.rx_byte = '0;
  endtask

  task automatic clr_counts();
    n_aack = 0; n_back = 0; n_rdy = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check1({tag, "_outs"}, 64'({bus.addr_ack, bus.byte_ack, bus.data_ready,
                               bus.i2c_rw, bus.i2c_stop, bus.frame_err}), 64'(0));
    check1({tag, "_data_out"}, bus.data_out, 64'(0));
  endtask

  logic       rs, rp, rv;
  logic [7:0] rb;

  initial begin
    rst = 1'b1;
    bus.start_detect = 0; bus.stop_detect = 0; bus.byte_valid = 0; bus.rx_byte = '0;
    model_reset();
    clr_counts();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk); rst = 1'b0;

    // START; write addr; 01..08; STOP
    tbl[0] = '{1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 1, 8'h78, 1, 0, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++)
      tbl[2+i] = '{0, 0, 1, 8'(i + 1), 0, 1, (i == 7), 0, 0, 0};
    tbl[10] = '{0, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].s, tbl[i].p, tbl[i].v, tbl[i].b);
      check1($sformatf("vec%0d", i),
             64'({bus.addr_ack, bus.byte_ack, bus.data_ready, bus.i2c_rw, bus.i2c_stop, bus.frame_err}),
             64'({tbl[i].aack, tbl[i].back, tbl[i].rdy, tbl[i].rw, tbl[i].stp, tbl[i].err}));
    end
    check1("vec_block", bus.data_out, 64'h0102030405060708);

    // Three back-to-back blocks in one transfer
    step(1, 0, 0, 0); step(0, 0, 1, 8'h78);
    for (int i = 0; i < 24; i++) begin
      step(0, 0, 1, 8'(i));
      if (i % 8 == 7) begin
        check1($sformatf("stream_rdy%0d", i / 8), 64'(bus.data_ready), 64'(1));
        case (i / 8)
          0: check1("stream_blk0", bus.data_out, 64'h0001020304050607);
          1: check1("stream_blk1", bus.data_out, 64'h08090A0B0C0D0E0F);
          default: check1("stream_blk2", bus.data_out, 64'h1011121314151617);
        endcase
      end
    end
    step(0, 1, 0, 0);
    check1("stream_no_err", 64'(bus.frame_err), 64'(0));

    // Read transfer: address acked, data ignored
    clr_counts();
    step(1, 0, 0, 0); step(0, 0, 1, 8'h79);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'hC0 + 8'(i));
    check1("read_aack", 64'(n_aack), 64'(1));
    check1("read_rw", 64'(bus.i2c_rw), 64'(1));
    check1("read_back_rdy", 64'(n_back + n_rdy), 64'(0));

    // Wrong address: nothing acked, rw keeps the read value
    clr_counts();
    step(1, 0, 0, 0); step(0, 0, 1, 8'h7A);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'h55);
    check1("nomatch_pulses", 64'(n_aack + n_back + n_rdy), 64'(0));
    check1("nomatch_rw", 64'(bus.i2c_rw), 64'(1));

    // 8th byte coincides with STOP
    step(1, 0, 0, 0); step(0, 0, 1, 8'h78);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 8'h21 + 8'(i));
    step(0, 1, 1, 8'h28);
    check1("stopbyte_rdy", 64'(bus.data_ready), 64'(1));
    check1("stopbyte_stop", 64'(bus.i2c_stop), 64'(1));
    check1("stopbyte_err", 64'(bus.frame_err), 64'(0));
    check1("stopbyte_blk", bus.data_out, 64'h2122232425262728);

    // Partial block then STOP, then START clears status
    clr_counts();
    step(1, 0, 0, 0); step(0, 0, 1, 8'h78);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h90 + 8'(i));
    step(0, 1, 0, 0);
    check1("partial_err", 64'(bus.frame_err), 64'(1));
    check1("partial_rdy", 64'(n_rdy), 64'(0));
    step(1, 0, 0, 0);
    check1("restart_status", 64'({bus.frame_err, bus.i2c_stop}), 64'(0));

    // START with a byte drops the byte; START with STOP acts as START
    step(0, 0, 1, 8'h78); step(0, 0, 1, 8'h01);
    step(1, 0, 1, 8'h02);
    step(1, 1, 0, 0);
    check1("startstop_stop", 64'(bus.i2c_stop), 64'(0));

    // Reset in the middle of a block
    step(1, 0, 0, 0); step(0, 0, 1, 8'h78);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'h11 + 8'(i));
    @(negedge clk); rst = 1'b1; #1;
    check_all_zero("async_rst");
    model_reset();
    @(posedge clk); #1;
    check_all_zero("held_rst");
    @(negedge clk); rst = 1'b0;
    clr_counts();
    step(1, 0, 0, 0); step(0, 0, 1, 8'h78);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'hAA + 8'(i));
    check1("post_rst_rdy", 64'(n_rdy), 64'(1));
    check1("post_rst_blk", bus.data_out, 64'hAAABACADAEAFB0B1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(0, 99) < 4);
      rp = ($urandom_range(0, 99) < 3);
      rv = ($urandom_range(0, 99) < 60);
      case ($urandom_range(0, 3))
        0: rb = 8'h78;
        1: rb = 8'h79;
        default: rb = 8'($urandom);
      endcase
      step(rs, rp, rv, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
